// File: rtl/sin_sample_fifo_pkg.sv
// Shared sample-path constants for the CORDIC mirror stage and the DAC-side sample FIFO.
// Also holds the saturating increment used by the drop counter.
package sin_sample_fifo_pkg;

    localparam int SAMPLE_W   = 16;
    localparam int FIFO_DEPTH = 16;
    localparam int FIFO_AW    = 4;
    localparam int DROP_W     = 8;

    function automatic logic [DROP_W-1:0] sat_inc(input logic [DROP_W-1:0] v);
        if (v == {DROP_W{1'b1}}) begin
            return v;
        end else begin
            return v + 8'd1;
        end
    endfunction

endpackage

// File: rtl/sin_sample_fifo_if.sv
// Sample-in / DAC-out handshake bundle of the sine sample FIFO.
// The master modport drives samples and consumer controls, the slave modport is the FIFO.
interface sin_sample_fifo_if;
    import sin_sample_fifo_pkg::*;

    logic                  wen_in;
    logic [SAMPLE_W-1:0]   sin_in;
    logic                  out_valid;
    logic [SAMPLE_W-1:0]   out_data;
    logic                  out_ready;
    logic [FIFO_AW:0]      level;
    logic                  full;
    logic                  ovf;
    logic                  ovf_clr;
    logic [DROP_W-1:0]     drop_cnt;

    modport master (
        output wen_in, sin_in, out_ready, ovf_clr,
        input  out_valid, out_data, level, full, ovf, drop_cnt
    );

    modport slave (
        input  wen_in, sin_in, out_ready, ovf_clr,
        output out_valid, out_data, level, full, ovf, drop_cnt
    );

endinterface

// File: rtl/sin_sample_fifo_dpram.sv
// Sample storage: DEPTH x W, one synchronous write port, one asynchronous read port.
// Storage is deliberately not reset; validity is tracked by the FIFO control.
module fifo_dpram #(
    parameter int W     = 16,
    parameter int DEPTH = 16,
    parameter int AW    = 4
) (
    input  logic          clk,
    input  logic          we,
    input  logic [AW-1:0] waddr,
    input  logic [W-1:0]  wdata,
    input  logic [AW-1:0] raddr,
    output logic [W-1:0]  rdata
);

    logic [W-1:0] mem_r [DEPTH];

    // synchronous write port
    always_ff @(posedge clk) begin
        if (we) begin
            mem_r[waddr] <= wdata;
        end
    end

    assign rdata = mem_r[raddr];

endmodule

// File: rtl/sin_sample_fifo.sv
// First-word-fall-through sample FIFO between the CORDIC mirror stage and the DAC serializer.
// All outputs are registered; the head register is loaded with the next head sample each edge.
module sin_sample_fifo
    import sin_sample_fifo_pkg::*;
#(
    parameter int W     = SAMPLE_W,
    parameter int DEPTH = FIFO_DEPTH,
    parameter int AW    = FIFO_AW
) (
    input  logic               clk,
    input  logic               reset,
    sin_sample_fifo_if.slave   bus
);

    logic [AW-1:0]     wr_ptr_r;
    logic [AW-1:0]     rd_ptr_r;
    logic [AW:0]       level_r;
    logic              out_valid_r;
    logic              full_r;
    logic [W-1:0]      out_data_r;
    logic              ovf_r;
    logic [DROP_W-1:0] drop_cnt_r;

    logic              push_s;
    logic              pop_s;
    logic              drop_s;
    logic [AW-1:0]     wr_ptr_next_s;
    logic [AW-1:0]     rd_ptr_next_s;
    logic [AW:0]       level_after_pop_s;
    logic [AW:0]       level_next_s;
    logic [W-1:0]      head_next_s;
    logic [W-1:0]      ram_rdata_s;
    logic              ovf_next_s;
    logic [DROP_W-1:0] drop_cnt_next_s;

    fifo_dpram #(
        .W     (W),
        .DEPTH (DEPTH),
        .AW    (AW)
    ) u_ram (
        .clk   (clk),
        .we    (push_s),
        .waddr (wr_ptr_r),
        .wdata (bus.sin_in),
        .raddr (rd_ptr_next_s),
        .rdata (ram_rdata_s)
    );

    // next-state of pointers, level and the head sample that will be visible after this edge
    always_comb begin
        pop_s             = out_valid_r & bus.out_ready;
        push_s            = bus.wen_in & (~full_r | pop_s);
        drop_s            = bus.wen_in & full_r & ~pop_s;
        wr_ptr_next_s     = push_s ? (wr_ptr_r + AW'(1)) : wr_ptr_r;
        rd_ptr_next_s     = pop_s  ? (rd_ptr_r + AW'(1)) : rd_ptr_r;
        level_after_pop_s = pop_s  ? (level_r - (AW+1)'(1)) : level_r;
        level_next_s      = push_s ? (level_after_pop_s + (AW+1)'(1)) : level_after_pop_s;
        // a sample entering an otherwise empty FIFO is not in the RAM yet, so bypass it
        if (level_next_s == (AW+1)'(0)) begin
            head_next_s = {W{1'b0}};
        end else if (push_s && (level_after_pop_s == (AW+1)'(0))) begin
            head_next_s = bus.sin_in;
        end else begin
            head_next_s = ram_rdata_s;
        end
    end

    // overflow flag and saturating drop counter; a drop outranks a clear in the same cycle
    always_comb begin
        ovf_next_s      = ovf_r;
        drop_cnt_next_s = drop_cnt_r;
        if (drop_s) begin
            ovf_next_s = 1'b1;
            if (bus.ovf_clr) begin
                drop_cnt_next_s = 8'd1;
            end else begin
                drop_cnt_next_s = sat_inc(drop_cnt_r);
            end
        end else if (bus.ovf_clr) begin
            ovf_next_s      = 1'b0;
            drop_cnt_next_s = 8'd0;
        end else begin
            ovf_next_s      = ovf_r;
            drop_cnt_next_s = drop_cnt_r;
        end
    end

    // control and output registers
    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr_r    <= {AW{1'b0}};
            rd_ptr_r    <= {AW{1'b0}};
            level_r     <= {(AW+1){1'b0}};
            out_valid_r <= 1'b0;
            full_r      <= 1'b0;
            out_data_r  <= {W{1'b0}};
            ovf_r       <= 1'b0;
            drop_cnt_r  <= {DROP_W{1'b0}};
        end else begin
            wr_ptr_r    <= wr_ptr_next_s;
            rd_ptr_r    <= rd_ptr_next_s;
            level_r     <= level_next_s;
            out_valid_r <= (level_next_s != (AW+1)'(0));
            full_r      <= (level_next_s == (AW+1)'(DEPTH));
            out_data_r  <= head_next_s;
            ovf_r       <= ovf_next_s;
            drop_cnt_r  <= drop_cnt_next_s;
        end
    end

    assign bus.out_valid = out_valid_r;
    assign bus.out_data  = out_data_r;
    assign bus.level     = level_r;
    assign bus.full      = full_r;
    assign bus.ovf       = ovf_r;
    assign bus.drop_cnt  = drop_cnt_r;

endmodule

// File: tb/tb_sin_sample_fifo.sv
// Directed + randomized bench for sin_sample_fifo against a queue-based reference model.
// Every cycle all outputs are compared with the model; key points also get fixed expectations.
module tb_sin_sample_fifo;
    import sin_sample_fifo_pkg::*;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    sin_sample_fifo_if bus();

    sin_sample_fifo dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    int          vectors     = 0;
    int          miscompares = 0;
    logic [15:0] q_m[$];
    logic        ovf_m;
    int          drop_m;
    string       phase;
    logic [15:0] seen[$];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s/%s observed=0x%0h expected=0x%0h", phase, tag, obs, exp);
        end
    endtask

    task automatic check_all();
        check("out_valid", 32'(bus.out_valid), (q_m.size() != 0) ? 32'd1 : 32'd0);
        check("out_data",  32'(bus.out_data),  (q_m.size() != 0) ? 32'(q_m[0]) : 32'd0);
        check("level",     32'(bus.level),     32'(q_m.size()));
        check("full",      32'(bus.full),      (q_m.size() == FIFO_DEPTH) ? 32'd1 : 32'd0);
        check("ovf",       32'(bus.ovf),       32'(ovf_m));
        check("drop_cnt",  32'(bus.drop_cnt),  32'(drop_m));
    endtask

    // One clock: apply inputs, advance the model by the FIFO rules, compare after the edge.
    task automatic step(input logic wen, input logic [15:0] d, input logic rdy,
                        input logic clr, input logic rst);
        bit pop_m, push_m, drop_e;
        bus.wen_in    = wen;
        bus.sin_in    = d;
        bus.out_ready = rdy;
        bus.ovf_clr   = clr;
        reset         = rst;
        pop_m  = (q_m.size() != 0) && rdy;
        push_m = wen && ((q_m.size() < FIFO_DEPTH) || pop_m);
        drop_e = wen && (q_m.size() == FIFO_DEPTH) && !pop_m;
        if (pop_m) seen.push_back(q_m[0]);
        @(posedge clk);
        if (rst) begin
            q_m.delete();
            ovf_m  = 1'b0;
            drop_m = 0;
        end else begin
            if (pop_m)  void'(q_m.pop_front());
            if (push_m) q_m.push_back(d);
            if (drop_e) begin
                ovf_m  = 1'b1;
                drop_m = clr ? 1 : ((drop_m < 255) ? drop_m + 1 : 255);
            end else if (clr) begin
                ovf_m  = 1'b0;
                drop_m = 0;
            end
        end
        #1;
        check_all();
    endtask

    initial begin
        bus.wen_in = 1'b0; bus.sin_in = 16'h0; bus.out_ready = 1'b0; bus.ovf_clr = 1'b0;
        reset = 1'b1; ovf_m = 1'b0; drop_m = 0;

        phase = "reset";
        step(1'b0, 16'h0, 1'b0, 1'b0, 1'b1);
        step(1'b0, 16'h0, 1'b0, 1'b0, 1'b1);

        phase = "t1_order";
        seen.delete();
        step(1'b1, 16'h1234, 1'b1, 1'b0, 1'b0);
        check("first_valid", 32'(bus.out_valid), 32'd1);
        check("first_data",  32'(bus.out_data),  32'h1234);
        step(1'b1, 16'h8001, 1'b1, 1'b0, 1'b0);
        step(1'b1, 16'h7FFF, 1'b1, 1'b0, 1'b0);
        for (int i = 0; i < 3; i++) step(1'b0, 16'h0, 1'b1, 1'b0, 1'b0);
        check("t1_n",  32'(seen.size()), 32'd3);
        check("t1_s0", 32'(seen[0]), 32'h1234);
        check("t1_s1", 32'(seen[1]), 32'h8001);
        check("t1_s2", 32'(seen[2]), 32'h7FFF);

        phase = "t2_fill";
        for (int i = 0; i < 16; i++) step(1'b1, 16'(i), 1'b0, 1'b0, 1'b0);
        check("t2_full",  32'(bus.full),  32'd1);
        check("t2_level", 32'(bus.level), 32'd16);
        step(1'b1, 16'h00EE, 1'b0, 1'b0, 1'b0);
        check("t2_ovf",  32'(bus.ovf),      32'd1);
        check("t2_drop", 32'(bus.drop_cnt), 32'd1);
        seen.delete();
        for (int i = 0; i < 18; i++) step(1'b0, 16'h0, 1'b1, 1'b0, 1'b0);
        check("t2_n", 32'(seen.size()), 32'd16);
        for (int i = 0; i < 16; i++) check("t2_order", 32'(seen[i]), 32'(i));
        step(1'b0, 16'h0, 1'b0, 1'b1, 1'b0);
        check("t2_clr", 32'(bus.ovf), 32'd0);

        phase = "t3_full_pp";
        for (int i = 0; i < 16; i++) step(1'b1, 16'(16'h100 + i), 1'b0, 1'b0, 1'b0);
        seen.delete();
        for (int i = 0; i < 5; i++) step(1'b1, 16'(16'h200 + i), 1'b1, 1'b0, 1'b0);
        check("t3_level", 32'(bus.level), 32'd16);
        check("t3_ovf",   32'(bus.ovf),   32'd0);
        for (int i = 0; i < 5; i++) check("t3_order", 32'(seen[i]), 32'(16'h100 + i));

        phase = "t4_sat";
        for (int i = 0; i < 300; i++) step(1'b1, 16'($urandom), 1'b0, 1'b0, 1'b0);
        check("t4_sat", 32'(bus.drop_cnt), 32'd255);
        step(1'b1, 16'h5555, 1'b0, 1'b1, 1'b0);
        check("t4_clr_ovf",  32'(bus.ovf),      32'd1);
        check("t4_clr_drop", 32'(bus.drop_cnt), 32'd1);

        phase = "t5_reset";
        step(1'b0, 16'h0, 1'b0, 1'b1, 1'b1);
        for (int i = 0; i < 9; i++) step(1'b1, 16'($urandom), 1'b0, 1'b0, 1'b0);
        check("t5_level9", 32'(bus.level), 32'd9);
        step(1'b1, 16'h0, 1'b0, 1'b0, 1'b1);
        check("t5_level",    32'(bus.level),     32'd0);
        check("t5_valid",    32'(bus.out_valid), 32'd0);
        check("t5_data",     32'(bus.out_data),  32'd0);
        step(1'b1, 16'h00AA, 1'b0, 1'b0, 1'b0);
        check("t5_first", 32'(bus.out_data), 32'h00AA);
        step(1'b0, 16'h0, 1'b1, 1'b0, 1'b0);

        phase = "t6_random";
        for (int i = 0; i < 40; i++) begin
            step(1'($urandom_range(0, 3) != 0), 16'($urandom),
                 1'($urandom_range(0, 2) == 0), 1'($urandom_range(0, 9) == 0), 1'b0);
            check("level_bound", (bus.level <= 5'd16) ? 32'd1 : 32'd0, 32'd1);
        end
        for (int i = 0; i < 20; i++) step(1'b0, 16'h0, 1'b1, 1'b0, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
